// File: rtl/sram_sp_arbiter_pkg.sv
// Shared definitions for the single-port SRAM arbiter.
//   - state_e    : controller state (init sweep / normal service)
//   - sram_cmd_t : one registered macro command (CEB, WEB, A, D)
//   - NUM_PORTS  : number of requesters sharing the macro
//   - cmd_idle() : turn a command into a no-op while keeping A/D stable
package sram_sp_arbiter_pkg;

    localparam int unsigned NUM_PORTS  = 2;

    // Geometry of the SRAM macro this slice is built around.
    localparam int unsigned CMD_DATA_W = 32;
    localparam int unsigned CMD_ADDR_W = 7;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } state_e;

    typedef struct packed {
        logic                  ceb;
        logic                  web;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] data;
    } sram_cmd_t;

    // Deselect the macro but hold address/data so the pins do not toggle.
    function automatic sram_cmd_t cmd_idle(input sram_cmd_t prev);
        sram_cmd_t c;
        c     = prev;
        c.ceb = 1'b1;
        c.web = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/sram_sp_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: two request/response port pairs.
//   master : requester view (drives req*, receives ready and resp*)
//   slave  : arbiter view (receives req*, drives ready and resp*)
interface sram_sp_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 7
);

    logic              req0_valid;
    logic              req0_ready;
    logic              req0_wen;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              resp0_valid;
    logic [DATA_W-1:0] resp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_wen;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              resp1_valid;
    logic [DATA_W-1:0] resp1_rdata;

    modport master (
        output req0_valid, req0_wen, req0_addr, req0_wdata,
        input  req0_ready, resp0_valid, resp0_rdata,
        output req1_valid, req1_wen, req1_addr, req1_wdata,
        input  req1_ready, resp1_valid, resp1_rdata
    );

    modport slave (
        input  req0_valid, req0_wen, req0_addr, req0_wdata,
        output req0_ready, resp0_valid, resp0_rdata,
        input  req1_valid, req1_wen, req1_addr, req1_wdata,
        output req1_ready, resp1_valid, resp1_rdata
    );

endinterface

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin grant logic.
//   clock, reset    : clock and asynchronous active-high reset
//   valid0, valid1  : request valids
//   enable          : grants are only issued while high
//   grant0, grant1  : combinational one-hot grant (both low when idle)
// A grant is taken as a completed handshake, so the last-served flop
// updates on every grant. After reset port 1 counts as last served, so
// port 0 wins the first contested cycle.
module sram_rr_arb2 (
    input  logic clock,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic enable,
    output logic grant0,
    output logic grant1
);

    logic last_q;  // 1: port 1 was served most recently
    logic last_d;

    always_comb begin
        grant0 = enable & valid0 & (~valid1 | last_q);
        grant1 = enable & valid1 & (~valid0 | ~last_q);
        last_d = last_q;
        if (grant0) begin
            last_d = 1'b0;
        end else if (grant1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_sp_arbiter.sv
// Shares one single-port SRAM macro (active-low CEB/WEB, 1-cycle read
// latency) between two requesters with round-robin arbitration. After
// reset or a clear pulse, every entry is first written with INIT_VAL.
//   clock, reset   : clock and asynchronous active-high reset
//   clear          : one-cycle pulse restarting the init sweep
//   init_done      : high once a sweep has completed
//   bus            : two request/response ports (slave side)
//   sram_CEB/WEB/A/D : registered macro command
//   sram_Q         : macro read data, forwarded to both resp_rdata
// A read accepted at edge E0 is driven to the macro after E0, sampled by
// the macro at E1, and its response is valid for the cycle after E1.
module sram_sp_arbiter
    import sram_sp_arbiter_pkg::*;
#(
    parameter int unsigned       DATA_W   = CMD_DATA_W,
    parameter int unsigned       ADDR_W   = CMD_ADDR_W,
    parameter int unsigned       DEPTH    = 128,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    output logic              init_done,
    sram_sp_arbiter_if.slave  bus,
    output logic              sram_CEB,
    output logic              sram_WEB,
    output logic [ADDR_W-1:0] sram_A,
    output logic [DATA_W-1:0] sram_D,
    input  logic [DATA_W-1:0] sram_Q
);

    // The command struct is sized for the macro; refuse other geometries.
    if (DATA_W != CMD_DATA_W || ADDR_W != CMD_ADDR_W) begin : g_bad_width
        $error("sram_sp_arbiter: DATA_W/ADDR_W must match the macro geometry");
    end
    if (DEPTH == 0 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("sram_sp_arbiter: DEPTH must be in 1..2**ADDR_W");
    end

    // One extra counter bit so DEPTH == 2**ADDR_W does not wrap.
    localparam logic [ADDR_W:0] LastAddr = (ADDR_W + 1)'(DEPTH - 1);

    state_e               state_q, state_d;
    logic [ADDR_W:0]      init_cnt_q, init_cnt_d;
    logic                 init_done_q, init_done_d;
    sram_cmd_t            cmd_q, cmd_d;

    // Read tag pipe: stage 1 travels with the command, stage 2 is the response.
    logic                 tag_vld_q, tag_vld_d;
    logic                 tag_port_q, tag_port_d;
    logic [NUM_PORTS-1:0] resp_vld_q, resp_vld_d;

    logic                 arb_en;
    logic                 grant0, grant1;
    logic                 acc;
    logic                 acc_port;
    logic                 acc_wen;
    logic [ADDR_W-1:0]    acc_addr;
    logic [DATA_W-1:0]    acc_wdata;

    assign arb_en = (state_q == StRun);

    sram_rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .enable (arb_en),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // A grant is only given to a valid port, so grant alone marks a handshake.
    always_comb begin
        acc       = grant0 | grant1;
        acc_port  = grant1;
        acc_wen   = grant1 ? bus.req1_wen   : bus.req0_wen;
        acc_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
        acc_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        cmd_d       = cmd_idle(cmd_q);
        tag_vld_d   = 1'b0;
        tag_port_d  = 1'b0;

        unique case (state_q)
            StInit: begin
                cmd_d = '{ceb: 1'b0, web: 1'b0,
                          addr: init_cnt_q[ADDR_W-1:0], data: INIT_VAL};
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LastAddr) begin
                    state_d     = StRun;
                    init_done_d = 1'b1;
                end
            end
            StRun: begin
                if (acc) begin
                    cmd_d = '{ceb: 1'b0, web: ~acc_wen, addr: acc_addr, data: acc_wdata};
                    tag_vld_d  = ~acc_wen;
                    tag_port_d = acc_port;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase

        // Clear restarts the sweep; whatever is issued this cycle still goes out
        // and reads already in the tag pipe are left to complete.
        if (clear) begin
            state_d     = StInit;
            init_cnt_d  = '0;
            init_done_d = 1'b0;
        end

        resp_vld_d = '0;
        if (tag_vld_q) begin
            resp_vld_d[tag_port_q] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StInit;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            cmd_q       <= '{ceb: 1'b1, web: 1'b1, addr: '0, data: '0};
            tag_vld_q   <= 1'b0;
            tag_port_q  <= 1'b0;
            resp_vld_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            cmd_q       <= cmd_d;
            tag_vld_q   <= tag_vld_d;
            tag_port_q  <= tag_port_d;
            resp_vld_q  <= resp_vld_d;
        end
    end

    assign init_done       = init_done_q;
    assign sram_CEB        = cmd_q.ceb;
    assign sram_WEB        = cmd_q.web;
    assign sram_A          = cmd_q.addr;
    assign sram_D          = cmd_q.data;

    // The macro output is only meaningful while the matching resp_valid is high.
    assign bus.resp0_valid = resp_vld_q[0];
    assign bus.resp1_valid = resp_vld_q[1];
    assign bus.resp0_rdata = sram_Q;
    assign bus.resp1_rdata = sram_Q;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Self-checking bench for sram_sp_arbiter: directed scenarios followed by
// randomized traffic, compared each cycle against a transaction-level model.
module tb_sram_sp_arbiter;

    localparam int unsigned       DW       = 32;
    localparam int unsigned       AW       = 7;
    localparam int unsigned       DEPTH    = 128;
    localparam logic [DW-1:0]     INIT_VAL = 32'h0;

    logic          clock = 1'b0;
    logic          reset;
    logic          clear;
    logic          init_done;
    logic          sram_CEB;
    logic          sram_WEB;
    logic [AW-1:0] sram_A;
    logic [DW-1:0] sram_D;
    logic [DW-1:0] sram_Q;

    sram_sp_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sram_sp_arbiter #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .init_done (init_done),
        .bus       (bus),
        .sram_CEB  (sram_CEB),
        .sram_WEB  (sram_WEB),
        .sram_A    (sram_A),
        .sram_D    (sram_D),
        .sram_Q    (sram_Q)
    );

    always #5 clock = ~clock;

    // Behavioural SRAM macro: 1-cycle read, garbage on Q when not reading.
    logic [DW-1:0] macro_mem [0:(1 << AW) - 1];
    always @(posedge clock) begin
        if (!sram_CEB && !sram_WEB) begin
            macro_mem[sram_A] <= sram_D;
            sram_Q            <= $urandom;
        end else if (!sram_CEB) begin
            sram_Q <= macro_mem[sram_A];
        end else begin
            sram_Q <= $urandom;
        end
    end

    // Reference model: memory contents, sweep progress, last-served port,
    // and a queue of expected read responses with the edge they appear after.
    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            due;
    } resp_t;

    logic [DW-1:0] ref_mem [0:DEPTH-1];
    bit            ref_init;
    int            ref_cnt;
    bit            ref_done;
    int            ref_last;
    bit            ref_ceb;
    bit            ref_web;
    logic [AW-1:0] ref_a;
    logic [DW-1:0] ref_d;
    resp_t         pend [$];
    int            cyc;
    int            n_cmp;
    int            n_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: observed %0h required %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic ref_reset();
        ref_init = 1'b1;
        ref_cnt  = 0;
        ref_done = 1'b0;
        ref_last = 1;
        ref_ceb  = 1'b1;
        ref_web  = 1'b1;
        ref_a    = '0;
        ref_d    = '0;
        pend.delete();
    endtask

    // Called at edge+1; checks ready mid-cycle, advances the model across the
    // next rising edge and checks all registered outputs at edge+1.
    task automatic cycle();
        bit            r0, r1, clr, ev0, ev1;
        int            hp;
        bit            hw;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd, edata;
        resp_t         e;
        #4;
        r0 = 1'b0;
        r1 = 1'b0;
        if (!reset && !ref_init) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (ref_last == 1) r0 = 1'b1; else r1 = 1'b1;
            end else if (bus.req0_valid) begin
                r0 = 1'b1;
            end else if (bus.req1_valid) begin
                r1 = 1'b1;
            end
        end
        check_eq("req0_ready", bus.req0_ready, r0);
        check_eq("req1_ready", bus.req1_ready, r1);
        hp  = r0 ? 0 : (r1 ? 1 : -1);
        hw  = r1 ? bus.req1_wen   : bus.req0_wen;
        ha  = r1 ? bus.req1_addr  : bus.req0_addr;
        hd  = r1 ? bus.req1_wdata : bus.req0_wdata;
        clr = clear;

        @(posedge clock);
        cyc++;
        if (reset) begin
            ref_reset();
        end else begin
            if (ref_init) begin
                ref_ceb          = 1'b0;
                ref_web          = 1'b0;
                ref_a            = AW'(ref_cnt);
                ref_d            = INIT_VAL;
                ref_mem[ref_cnt] = INIT_VAL;
                if (ref_cnt == DEPTH - 1) begin
                    ref_init = 1'b0;
                    ref_done = 1'b1;
                end
                ref_cnt++;
            end else if (hp >= 0) begin
                ref_ceb  = 1'b0;
                ref_web  = !hw;
                ref_a    = ha;
                ref_d    = hd;
                ref_last = hp;
                if (hw) ref_mem[ha] = hd;
                else    pend.push_back('{port: hp, data: ref_mem[ha], due: cyc + 1});
            end else begin
                ref_ceb = 1'b1;
                ref_web = 1'b1;
            end
            if (clr) begin
                ref_init = 1'b1;
                ref_cnt  = 0;
                ref_done = 1'b0;
            end
        end
        #1;
        ev0   = 1'b0;
        ev1   = 1'b0;
        edata = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e     = pend.pop_front();
            ev0   = (e.port == 0);
            ev1   = (e.port == 1);
            edata = e.data;
        end
        check_eq("sram_CEB", sram_CEB, ref_ceb);
        check_eq("sram_WEB", sram_WEB, ref_web);
        check_eq("sram_A", sram_A, ref_a);
        check_eq("sram_D", sram_D, ref_d);
        check_eq("init_done", init_done, ref_done);
        check_eq("resp0_valid", bus.resp0_valid, ev0);
        check_eq("resp1_valid", bus.resp1_valid, ev1);
        if (ev0) check_eq("resp0_rdata", bus.resp0_rdata, edata);
        if (ev1) check_eq("resp1_rdata", bus.resp1_rdata, edata);
    endtask

    task automatic set_req(input int p, input bit v, input bit w, input int a,
                           input logic [DW-1:0] d);
        if (p == 0) begin
            bus.req0_valid = v;
            bus.req0_wen   = w;
            bus.req0_addr  = AW'(a);
            bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v;
            bus.req1_wen   = w;
            bus.req1_addr  = AW'(a);
            bus.req1_wdata = d;
        end
    endtask

    task automatic idle();
        set_req(0, 1'b0, 1'b0, 0, '0);
        set_req(1, 1'b0, 1'b0, 0, '0);
        clear = 1'b0;
    endtask

    task automatic one(input int p, input bit w, input int a, input logic [DW-1:0] d);
        set_req(p, 1'b1, w, a, d);
        cycle();
        idle();
    endtask

    task automatic idle_cycles(input int n);
        idle();
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Runs a full init sweep with a cycle bound and checks its write count.
    task automatic wait_sweep(input string tag);
        int nw;
        nw = 0;
        idle();
        for (int i = 0; i < DEPTH + 40; i++) begin
            cycle();
            if (!sram_CEB && !sram_WEB) nw++;
            if (init_done) break;
        end
        check_eq({tag, "_writes"}, nw, DEPTH);
        check_eq({tag, "_done"}, init_done, 1'b1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        reset = 1'b1;
        idle();
        ref_reset();
        @(posedge clock);
        #1;

        // Reset held: macro idle, nothing valid.
        idle_cycles(3);
        reset = 1'b0;
        wait_sweep("sweep0");

        // Write then read on port 0.
        one(0, 1'b1, 5, 32'hDEAD_BEEF);
        one(0, 1'b0, 5, '0);
        idle_cycles(3);

        // Contended reads from both ports.
        one(0, 1'b1, 1, 32'h1111_0001);
        one(1, 1'b1, 2, 32'h2222_0002);
        set_req(0, 1'b1, 1'b0, 1, '0);
        set_req(1, 1'b1, 1'b0, 2, '0);
        for (int i = 0; i < 4; i++) cycle();
        idle_cycles(3);

        // Back-to-back reads on port 1.
        for (int a = 10; a < 13; a++) one(1, 1'b1, a, DW'(32'hA000_0000 + a));
        for (int a = 10; a < 13; a++) begin
            set_req(1, 1'b1, 1'b0, a, '0);
            cycle();
        end
        idle_cycles(3);

        // Read, then clear next cycle: read completes, sweep erases the write.
        one(0, 1'b1, 20, 32'h1234_5678);
        one(0, 1'b0, 20, '0);
        clear = 1'b1;
        cycle();
        wait_sweep("sweep1");
        one(0, 1'b0, 20, '0);
        idle_cycles(3);

        // Reset right after a read handshake drops the response.
        one(1, 1'b0, 10, '0);
        reset = 1'b1;
        idle_cycles(2);
        reset = 1'b0;
        wait_sweep("sweep2");

        // Randomized traffic with occasional clear and reset.
        for (int i = 0; i < 1500; i++) begin
            set_req(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)), $urandom);
            set_req(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)), $urandom);
            clear = ($urandom_range(0, 199) == 0);
            if (!reset && $urandom_range(0, 399) == 0) begin
                reset = 1'b1;
            end else begin
                reset = 1'b0;
            end
            cycle();
        end
        reset = 1'b0;
        idle_cycles(DEPTH + 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_sp_arbiter.md
Name: sram_sp_arbiter

Overview:
- Shares one single-port SRAM macro (active-low CEB/WEB, 1-cycle read latency) between two requesters using round-robin arbitration.
- After reset, or on a clear request, a built-in sequencer writes INIT_VAL to every entry before any requester is served.
- Sits between cache/tag-array logic and the SRAM macro instance.
- All macro control signals are registered, so the macro is idle (CEB=1) throughout reset.

Parameters:
- DATA_W, 32, word width; equals the macro Bits.
- ADDR_W, 7, address width; equals the macro Add_Width.
- DEPTH, 128, number of entries swept by init; must satisfy DEPTH <= 2^ADDR_W.
- INIT_VAL, 0, value written to every entry during init.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  one-cycle pulse that restarts the init sweep.
- init_done  out  1  high once a sweep has completed.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted.
- req0_wen  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  port 0 address.
- req0_wdata  in  DATA_W  port 0 write data.
- resp0_valid  out  1  port 0 read data valid; one-cycle pulse.
- resp0_rdata  out  DATA_W  port 0 read data.
- req1_*, resp1_*: same set as port 0, for port 1.
- sram_CEB  out  1  macro chip enable, active-low, registered.
- sram_WEB  out  1  macro write enable, active-low, registered.
- sram_A  out  ADDR_W  macro address, registered.
- sram_D  out  DATA_W  macro write data, registered.
- sram_Q  in  DATA_W  macro read data.

Behaviour:
- Reset values: state=INIT, init_cnt=0, init_done=0, last_grant=1 (port 0 favoured first), sram_CEB=1, sram_WEB=1, sram_A=0, sram_D=0, both resp_valid=0, both read tags cleared.
- FSM states: INIT and RUN.
- INIT:
  - Each cycle, the command register loads CEB=0, WEB=0, A=init_cnt, D=INIT_VAL, then init_cnt increments.
  - The cycle that issues address DEPTH-1 moves the FSM to RUN and sets init_done=1.
  - Exactly DEPTH writes are issued.
  - Both req_ready are 0 throughout INIT.
- RUN, arbitration:
  - grant = the valid port; if both ports are valid, grant the port that is not last_grant.
  - reqN_ready = grant==N. Ready is combinational from valid and state; at most one ready is high per cycle.
- RUN, accepted request (valid && ready at edge E0):
  - The command register loads CEB=0, WEB=!wen, A=addr, D=wdata.
  - last_grant is set to N.
- RUN, no accepted request: the command register loads CEB=1, WEB=1; A and D hold their previous values.
- Read latency:
  - A read accepted at E0 reaches the macro at E1.
  - respN_valid is high for exactly the one cycle after E1, with respN_rdata = sram_Q.
  - Total latency is 2 cycles after the handshake; back-to-back reads are fully pipelined.
  - A two-stage tag pipe (valid bit and port id) carries each read to its response.
  - Writes produce no response.
- No backpressure on responses: a requester must consume resp in its valid cycle.
- resp_rdata is don't-care when resp_valid=0, because the macro returns random data when it is not reading.
- clear:
  - A clear sampled in RUN moves the FSM to INIT, sets init_cnt=0 and init_done=0; ready is 0 from the next cycle.
  - Reads already accepted complete normally: tags are not flushed, and resp still pulses.
  - A request whose handshake coincides with the clear edge is still issued.
  - clear during INIT restarts the sweep at 0.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight reads are dropped with no resp.
- Address width: init_cnt is ADDR_W+1 bits wide, so DEPTH=2^ADDR_W causes no wrap.

Decomposition:
- Shared package:
  - State enum {INIT, RUN}.
  - Command struct {ceb, web, addr, data}.
  - Constant NUM_PORTS=2.
- One sub-module, sram_rr_arb2: 2-way round-robin grant logic holding the last_grant flop. Inputs: valid0, valid1, enable. Outputs: grant0, grant1.
- Init sequencer, command register and tag pipe stay in the top module.

Test Plan:
- Reset release, DEPTH=128:
  - sram_CEB=1 during reset.
  - Exactly 128 writes of INIT_VAL to addresses 0..127 in consecutive cycles.
  - init_done rises the cycle after address 127 is issued.
  - No ready during the sweep.
- Port 0 writes 0xDEADBEEF to address 5, then reads address 5 → resp0_valid exactly 2 cycles after the read handshake with rdata 0xDEADBEEF; resp1_valid stays 0.
- Both ports hold valid reads (addr 1 and 2) for 4 cycles → grants alternate 0,1,0,1; each response is routed to the correct port with the correct data.
- Back-to-back reads of addresses 10, 11, 12 on port 1 → resp1_valid high for 3 consecutive cycles with the matching data.
- Read accepted, then clear in the next cycle → that read's resp still delivers; a full 128-entry re-sweep follows; a pre-clear written value then reads back as INIT_VAL.
- reset asserted 1 cycle after a read handshake → no resp pulse; the init sweep restarts from address 0.
